ycr_clk_gate_n: RTL

- Parametrised N-source sleep/wake clock gate for a RISC-V core or subsystem clock.
- Software raises dst_idle; after a programmable entry delay, the block gates clk_out.
- The clock is restored when any enabled IRQ source fires. After wake, the clock is held on for a programmable guard time before a new sleep can start.
- Sits between the ungated clk_in root and the gated core clock domain. Its own FSM always runs on ungated clk_in.

---
 rtl/ycr_clk_gate_n.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/ycr_clk_gate_n.sv
// rtl/ycr_clk_gate_n.sv - N-source sleep/wake clock gate with IRQ wake-up
//
// ycr_clk_gate_n
//   Gates a core clock after software signals idle and a programmable entry
//   delay expires. Any enabled IRQ restores the clock, and a guard time must
//   elapse before a new sleep can start. All block logic runs on ungated clk_in.
//
// Ports
//   clk_in        in   ungated source clock
//   reset_n       in   asynchronous active-low reset
//   cfg_mode      in   00 no gating, 01 IRQ-wake gating, 10 force gate, 11 as 00
//   cfg_irq_mask  in   per-source wake enable
//   cfg_entry_dly in   cycles between idle detection and clock removal
//   cfg_wake_dly  in   guard cycles after wake before re-arming
//   dst_idle      in   asynchronous sleep request (level)
//   irq           in   wake sources, already in the clk_in domain (level)
//   wakeup        out  one-cycle pulse on a wake event
//   wake_src      out  masked irq captured at the last wake event
//   sleep_active  out  high while in SLEEP
//   clk_enb       out  enable driving the gate cell
//   clk_out       out  gated clock

// Two-flop synchroniser, resets low.
module ctech_dsync_high #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= in_data;
      s2_q <= s1_q;
    end
  end

  assign out_data = s2_q;

endmodule

// Latch-based clock gate: enable is captured while CLK is low so GCLK
// cannot glitch during the high phase.
module ctech_clk_gate (
  input  logic GATE,
  input  logic CLK,
  output logic GCLK
);

  logic en_l;

  always_latch begin
    if (!CLK) begin
      en_l = GATE;
    end
  end

  assign GCLK = CLK & en_l;

endmodule

module ycr_clk_gate_n #(
  parameter int NIRQ  = 4,
  parameter int DLY_W = 4
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic [1:0]       cfg_mode,
  input  logic [NIRQ-1:0]  cfg_irq_mask,
  input  logic [DLY_W-1:0] cfg_entry_dly,
  input  logic [DLY_W-1:0] cfg_wake_dly,
  input  logic             dst_idle,
  input  logic [NIRQ-1:0]  irq,
  output logic             wakeup,
  output logic [NIRQ-1:0]  wake_src,
  output logic             sleep_active,
  output logic             clk_enb,
  output logic             clk_out
);

  localparam int CFG_W = 2 + NIRQ + 2 * DLY_W;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ENTER = 2'd1,
    ST_SLEEP = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

  logic [CFG_W-1:0] cfg_ss;
  logic [1:0]       mode_ss;
  logic [NIRQ-1:0]  mask_ss;
  logic [DLY_W-1:0] entry_dly_ss;
  logic [DLY_W-1:0] wake_dly_ss;
  logic             idle_ss;
  logic             idle_r_q;
  logic             idle_ps;
  logic [NIRQ-1:0]  mirq;
  logic             any_irq;
  logic             gate_mode;

  state_t           state_q, state_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic             wakeup_q, wakeup_d;
  logic [NIRQ-1:0]  wake_src_q, wake_src_d;

  ctech_dsync_high #(.WIDTH(1)) u_idle_sync (
    .clk      (clk_in),
    .reset_n  (reset_n),
    .in_data  (dst_idle),
    .out_data (idle_ss)
  );

  // Configuration is quasi-static, so one bus-wide synchroniser is enough.
  ctech_dsync_high #(.WIDTH(CFG_W)) u_cfg_sync (
    .clk      (clk_in),
    .reset_n  (reset_n),
    .in_data  ({cfg_mode, cfg_irq_mask, cfg_entry_dly, cfg_wake_dly}),
    .out_data (cfg_ss)
  );

  assign {mode_ss, mask_ss, entry_dly_ss, wake_dly_ss} = cfg_ss;

  // idle_r tracks in every state, so an idle level held through GUARD
  // never looks like a fresh request.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      idle_r_q <= 1'b0;
    end else begin
      idle_r_q <= idle_ss;
    end
  end

  assign idle_ps   = idle_ss & ~idle_r_q;
  assign mirq      = irq & mask_ss;
  assign any_irq   = |mirq;
  assign gate_mode = (mode_ss == 2'b01);

  // State register
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      wakeup_q   <= 1'b0;
      wake_src_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wakeup_q   <= wakeup_d;
      wake_src_q <= wake_src_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wakeup_d   = 1'b0;
    wake_src_d = wake_src_q;
    case (state_q)
      ST_RUN: begin
        cnt_d = '0;
        // An all-zero mask would make the sleep unwakeable, so refuse it.
        if (gate_mode && idle_ps && (|mask_ss) && !any_irq) begin
          if (entry_dly_ss == '0) begin
            state_d = ST_SLEEP;
          end else begin
            state_d = ST_ENTER;
            cnt_d   = entry_dly_ss - DLY_W'(1);
          end
        end
      end
      ST_ENTER: begin
        if (!idle_ss || any_irq || !gate_mode) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_SLEEP;
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      ST_SLEEP: begin
        // IRQ wins over a simultaneous mode change so no wake is lost.
        if (any_irq) begin
          state_d    = ST_GUARD;
          cnt_d      = wake_dly_ss;
          wakeup_d   = 1'b1;
          wake_src_d = mirq;
        end else if (!gate_mode) begin
          state_d = ST_RUN;
        end
      end
      ST_GUARD: begin
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    clk_enb      = 1'b1;
    sleep_active = (state_q == ST_SLEEP);
    case (mode_ss)
      2'b10:   clk_enb = 1'b0;
      2'b01:   clk_enb = (state_q != ST_SLEEP);
      default: clk_enb = 1'b1;
    endcase
  end

  assign wakeup   = wakeup_q;
  assign wake_src = wake_src_q;

  ctech_clk_gate u_clk_gate (
    .GATE (clk_enb),
    .CLK  (clk_in),
    .GCLK (clk_out)
  );

endmodule
